// File: rtl/vehicle_ctrl_pkg.sv
// Shared types and helpers for the vehicle drive supervisor.
// - drive_state_t: drive FSM state encoding (also driven on the drive_state debug output).
// - cnt_width():   number of bits needed to count from 0 up to max_count.
package vehicle_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVING = 2'd1,
    RESERVE = 2'd2,
    STOPPED = 2'd3
  } drive_state_t;

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  localparam int DEBOUNCE_CYC_DEF = 4;
  localparam int COOLDOWN_CYC_DEF = 8;
  localparam int DEBOUNCE_W_DEF   = cnt_width(DEBOUNCE_CYC_DEF);
  localparam int COOLDOWN_W_DEF   = cnt_width(COOLDOWN_CYC_DEF);

endpackage

// File: rtl/overheat_debounce.sv
// Debounces one raw CPU over-temperature flag.
// Ports:
//   clk, areset_n : clock, asynchronous active-low reset
//   raw           : raw overheat input
//   flag          : registered debounced hot flag
//   set_pulse     : combinational, high in the cycle whose edge will set flag
//                   (lets the parent react on the same edge the flag rises)
module overheat_debounce
  import vehicle_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic areset_n,
  input  logic raw,
  output logic flag,
  output logic set_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);

  logic [CW-1:0] cnt;
  logic          hit;

  // cnt holds the number of consecutive disagreeing samples already seen;
  // the current disagreeing sample is the DEBOUNCE_CYC-th when cnt == DEBOUNCE_CYC-1.
  assign hit       = (raw != flag) && (cnt == CW'(DEBOUNCE_CYC - 1));
  assign set_pulse = hit && !flag;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (raw == flag) begin
      cnt <= '0;
    end else if (hit) begin
      flag <= ~flag;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vehicle_drive_supervisor.sv
// Vehicle drive supervisor: thermal shut-off with debounce/cool-down and a
// fuel-aware drive FSM. The two paths are fully independent.
// Ports:
//   clk, areset_n      : clock, asynchronous active-low reset
//   cpu_overheated     : raw per-channel overheat flags [N_CPU]
//   start, arrived     : trip request / destination reached
//   fuel_level         : unsigned fuel gauge, 0 = empty
//   shut_off_computer  : registered computer power-off request
//   overheat_status    : registered debounced hot flags [N_CPU]
//   keep_driving       : registered, state is DRIVING or RESERVE
//   low_fuel_warn      : registered, state is RESERVE
//   drive_state        : registered FSM state (drive_state_t encoding)
// Inputs are sampled on the rising edge; there is no handshake, every input is
// a level that the design evaluates each cycle.
module vehicle_drive_supervisor
  import vehicle_ctrl_pkg::*;
#(
  parameter int N_CPU        = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int COOLDOWN_CYC = 8,
  parameter int FUEL_W       = 8,
  parameter int FUEL_RESERVE = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic [N_CPU-1:0]  cpu_overheated,
  input  logic              start,
  input  logic              arrived,
  input  logic [FUEL_W-1:0] fuel_level,
  output logic              shut_off_computer,
  output logic [N_CPU-1:0]  overheat_status,
  output logic              keep_driving,
  output logic              low_fuel_warn,
  output logic [1:0]        drive_state
);

  localparam int CDW = cnt_width(COOLDOWN_CYC);

  // ---------------- thermal path ----------------
  logic [N_CPU-1:0] set_pulse;
  logic [CDW-1:0]   cd_cnt;

  for (genvar g = 0; g < N_CPU; g++) begin : g_db
    overheat_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk       (clk),
      .areset_n  (areset_n),
      .raw       (cpu_overheated[g]),
      .flag      (overheat_status[g]),
      .set_pulse (set_pulse[g])
    );
  end

  // A flag rising always wins: it asserts (or re-holds) the request and
  // restarts the cool-down from zero.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      shut_off_computer <= 1'b0;
      cd_cnt            <= '0;
    end else if (|set_pulse) begin
      shut_off_computer <= 1'b1;
      cd_cnt            <= '0;
    end else if (shut_off_computer && (overheat_status == '0)) begin
      if (cd_cnt == CDW'(COOLDOWN_CYC - 1)) begin
        shut_off_computer <= 1'b0;
        cd_cnt            <= '0;
      end else begin
        cd_cnt <= cd_cnt + 1'b1;
      end
    end else begin
      cd_cnt <= '0;
    end
  end

  // ---------------- drive FSM ----------------
  drive_state_t state, next_state;
  logic fuel_empty, fuel_low;

  assign fuel_empty = (fuel_level == '0);
  assign fuel_low   = (fuel_level <= FUEL_W'(FUEL_RESERVE));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && !arrived) begin
          if (fuel_empty)    next_state = STOPPED;
          else if (fuel_low) next_state = RESERVE;
          else               next_state = DRIVING;
        end
      end
      DRIVING: begin
        if (arrived)         next_state = IDLE;
        else if (fuel_empty) next_state = STOPPED;
        else if (fuel_low)   next_state = RESERVE;
      end
      RESERVE: begin
        if (arrived)         next_state = IDLE;
        else if (fuel_empty) next_state = STOPPED;
        else if (!fuel_low)  next_state = DRIVING;
      end
      STOPPED: begin
        if (!fuel_low)       next_state = IDLE;
      end
      default:               next_state = IDLE;
    endcase
  end

  // Outputs are registered alongside the state so they always match drive_state.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state         <= IDLE;
      keep_driving  <= 1'b0;
      low_fuel_warn <= 1'b0;
    end else begin
      state         <= next_state;
      keep_driving  <= (next_state == DRIVING) || (next_state == RESERVE);
      low_fuel_warn <= (next_state == RESERVE);
    end
  end

  assign drive_state = state;

endmodule

// File: tb/tb_vehicle_drive_supervisor.sv
// Directed + randomized bench for vehicle_drive_supervisor with a behavioural
// reference model updated once per rising edge.
module tb_vehicle_drive_supervisor;

  localparam int N_CPU = 2;
  localparam int DB    = 4;
  localparam int CD    = 8;
  localparam int FW    = 8;
  localparam int RES   = 16;

  localparam int S_IDLE = 0, S_DRIVING = 1, S_RESERVE = 2, S_STOPPED = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_CPU-1:0] cpu_overheated = '0;
  logic             start = 1'b0;
  logic             arrived = 1'b0;
  logic [FW-1:0]    fuel_level = '0;
  logic             shut_off_computer;
  logic [N_CPU-1:0] overheat_status;
  logic             keep_driving;
  logic             low_fuel_warn;
  logic [1:0]       drive_state;

  vehicle_drive_supervisor #(
    .N_CPU(N_CPU), .DEBOUNCE_CYC(DB), .COOLDOWN_CYC(CD),
    .FUEL_W(FW), .FUEL_RESERVE(RES)
  ) dut (
    .clk              (clk),
    .areset_n         (areset_n),
    .cpu_overheated   (cpu_overheated),
    .start            (start),
    .arrived          (arrived),
    .fuel_level       (fuel_level),
    .shut_off_computer(shut_off_computer),
    .overheat_status  (overheat_status),
    .keep_driving     (keep_driving),
    .low_fuel_warn    (low_fuel_warn),
    .drive_state      (drive_state)
  );

  // ---------------- reference model ----------------
  int               disagree_run [N_CPU]; // consecutive samples raw differs from flag
  logic [N_CPU-1:0] m_flags;
  bit               m_shut;
  int               cool_run;             // cycles spent fully cool while shut is on
  int               m_state;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    for (int i = 0; i < N_CPU; i++) disagree_run[i] = 0;
    m_flags  = '0;
    m_shut   = 0;
    cool_run = 0;
    m_state  = S_IDLE;
  endtask

  task automatic model_clock();
    logic [N_CPU-1:0] prev_flags;
    bit any_new_hot;
    int f;
    if (!areset_n) begin
      model_reset();
      return;
    end
    prev_flags  = m_flags;
    any_new_hot = 0;
    for (int i = 0; i < N_CPU; i++) begin
      if (cpu_overheated[i] == prev_flags[i]) disagree_run[i] = 0;
      else begin
        disagree_run[i]++;
        if (disagree_run[i] >= DB) begin
          m_flags[i]      = ~prev_flags[i];
          disagree_run[i] = 0;
          if (m_flags[i]) any_new_hot = 1;
        end
      end
    end
    if (any_new_hot) begin
      m_shut   = 1;
      cool_run = 0;
    end else if (m_shut && prev_flags == '0) begin
      cool_run++;
      if (cool_run >= CD) begin
        m_shut   = 0;
        cool_run = 0;
      end
    end else cool_run = 0;

    f = int'(fuel_level);
    case (m_state)
      S_IDLE:
        if (start && !arrived) m_state = (f == 0) ? S_STOPPED : (f <= RES) ? S_RESERVE : S_DRIVING;
      S_DRIVING:
        if (arrived) m_state = S_IDLE;
        else if (f == 0) m_state = S_STOPPED;
        else if (f <= RES) m_state = S_RESERVE;
      S_RESERVE:
        if (arrived) m_state = S_IDLE;
        else if (f == 0) m_state = S_STOPPED;
        else if (f > RES) m_state = S_DRIVING;
      default:
        if (f > RES) m_state = S_IDLE;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("shut_off", 32'(shut_off_computer), 32'(m_shut));
    chk("overheat_status", 32'(overheat_status), 32'(m_flags));
    chk("drive_state", 32'(drive_state), 32'(m_state));
    chk("keep_driving", 32'(keep_driving), 32'(m_state == S_DRIVING || m_state == S_RESERVE));
    chk("low_fuel_warn", 32'(low_fuel_warn), 32'(m_state == S_RESERVE));
  endtask

  // ---------------- driver ----------------
  // One clock: model advances with the edge, outputs compared at the falling edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    areset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_shut"}, 32'(shut_off_computer), 32'(0));
    chk({tag, "_keep"}, 32'(keep_driving), 32'(0));
    chk({tag, "_state"}, 32'(drive_state), 32'(S_IDLE));
    check_all();
  endtask

  initial begin
    model_reset();

    // 1: reset with random inputs
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cpu_overheated = N_CPU'($urandom);
      start = 1'($urandom);
      arrived = 1'($urandom);
      fuel_level = FW'($urandom);
      step();
    end
    chk("reset_status", 32'(overheat_status), 32'(0));
    cpu_overheated = '0; start = 0; arrived = 0; fuel_level = '0;
    areset_n = 1'b1;

    // 2: debounce rise on ch0, then a 3-cycle glitch on ch1
    cpu_overheated = 2'b01;
    step(3);
    chk("db_not_yet", 32'(shut_off_computer), 32'(0));
    step();
    chk("db_rise_shut", 32'(shut_off_computer), 32'(1));
    chk("db_rise_flag", 32'(overheat_status), 32'(2'b01));
    cpu_overheated = 2'b11;
    step(3);
    cpu_overheated = 2'b01;
    step();
    chk("glitch_ignored", 32'(overheat_status), 32'(2'b01));

    // 3: cool-down with a mid-count re-heat on ch1
    cpu_overheated = 2'b00;
    step(4);
    chk("cool_flag_drop", 32'(overheat_status), 32'(0));
    step(3);
    cpu_overheated = 2'b10;
    step(4);
    chk("reheat_shut", 32'(shut_off_computer), 32'(1));
    cpu_overheated = 2'b00;
    step(4);
    step(7);
    chk("cool_hold", 32'(shut_off_computer), 32'(1));
    step();
    chk("cool_done", 32'(shut_off_computer), 32'(0));

    // 4: trip through reserve and back
    fuel_level = 8'd100; start = 1; step(); start = 0;
    chk("trip_drive", 32'(drive_state), 32'(S_DRIVING));
    fuel_level = 8'd16; step();
    chk("trip_reserve_warn", 32'(low_fuel_warn), 32'(1));
    fuel_level = 8'd17; step();
    chk("trip_refuel", 32'(drive_state), 32'(S_DRIVING));
    arrived = 1; step(); arrived = 0;
    chk("trip_arrive", 32'(keep_driving), 32'(0));

    // 5: running empty
    fuel_level = 8'd10; start = 1; step(); start = 0;
    chk("empty_reserve", 32'(drive_state), 32'(S_RESERVE));
    fuel_level = 8'd0; step();
    chk("empty_stopped", 32'(drive_state), 32'(S_STOPPED));
    fuel_level = 8'd10; start = 1; arrived = 1; step(); start = 0; arrived = 0;
    chk("stopped_hold", 32'(drive_state), 32'(S_STOPPED));
    fuel_level = 8'd50; step();
    chk("stopped_refuel", 32'(drive_state), 32'(S_IDLE));

    // 6: arrival and empty in the same cycle
    fuel_level = 8'd100; start = 1; step(); start = 0;
    arrived = 1; fuel_level = 8'd0; step(); arrived = 0;
    chk("arrive_wins", 32'(drive_state), 32'(S_IDLE));

    // 6: async reset mid-trip and mid-cool-down
    fuel_level = 8'd100; start = 1; step(); start = 0;
    cpu_overheated = 2'b01; step(5);
    cpu_overheated = 2'b00; step(6);
    async_reset_check("rst_mid");
    step(2);
    areset_n = 1'b1;

    // randomized phase
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N_CPU; i++)
        if ($urandom_range(0, 5) == 0) cpu_overheated[i] = ~cpu_overheated[i];
      start   = ($urandom_range(0, 3) == 0);
      arrived = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: fuel_level = '0;
        1: fuel_level = FW'(RES);
        2: fuel_level = FW'(RES + 1);
        3: fuel_level = FW'($urandom_range(1, RES));
        default: fuel_level = FW'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        async_reset_check("rst_rand");
        step();
        areset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
